// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXEC,
        S_RTWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHAMT = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Shifts take their second operand from the shamt field instead of B.
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decode: fixed ADD/SUB classes or funct-driven
// R-type operations, flagging any funct the datapath cannot execute.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            funct,
    input  logic [1:0]            alu_op,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  funct_illegal
);

    always_comb begin
        alu_control   = ALU_CTRL_W'(ALU_ADD);
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_CTRL_W'(ALU_ADD);
            ALUOP_SUB: alu_control = ALU_CTRL_W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_CTRL_W'(ALU_ADD);
                    FN_SUB:  alu_control = ALU_CTRL_W'(ALU_SUB);
                    FN_AND:  alu_control = ALU_CTRL_W'(ALU_AND);
                    FN_OR:   alu_control = ALU_CTRL_W'(ALU_OR);
                    FN_SLT:  alu_control = ALU_CTRL_W'(ALU_SLT);
                    FN_SLL:  alu_control = ALU_CTRL_W'(ALU_SLL);
                    FN_SRL:  alu_control = ALU_CTRL_W'(ALU_SRL);
                    default: begin
                        alu_control   = '0;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_CTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with configurable memory wait states, start/halt handshake and opcode traps.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int MEM_WAIT    = 0,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0]            Opcode,
    input  logic [5:0]            Funct,
    input  logic                  Zero,
    output logic                  PCen,
    output logic                  IorD,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  DRWrite,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  ALU_en,
    output logic [1:0]            PCSrc,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal
);

    // The jump target {PC[31:26], Instr[25:0]} needs at least a 32-bit PC.
    if (WORD_LENGTH < 32) begin : g_word_length_check
        $error("mips_multicycle_control: WORD_LENGTH must be at least 32");
    end
    if ((MEM_WAIT < 0) || (MEM_WAIT > 7)) begin : g_mem_wait_check
        $error("mips_multicycle_control: MEM_WAIT must be in 0..7");
    end

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

    state_t                state;
    state_t                state_next;
    logic [2:0]            wait_cnt;
    logic                  wait_done;
    logic                  enter_wait;
    logic                  set_illegal;
    logic                  clear_illegal;
    logic [1:0]            alu_op;
    logic                  alu_use;
    logic [ALU_CTRL_W-1:0] dec_alu_control;
    logic                  funct_illegal;

    assign wait_done = (wait_cnt == 3'd0);

    assign alu_op = (state == S_RTEXEC) ? ALUOP_FUNCT :
                    (state == S_BRANCH) ? ALUOP_SUB   : ALUOP_ADD;

    mips_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .funct         (Funct),
        .alu_op        (alu_op),
        .alu_control   (dec_alu_control),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_next    = state;
        set_illegal   = 1'b0;
        clear_illegal = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_next    = S_FETCH;
                    clear_illegal = 1'b1;
                end
            end
            S_FETCH:  if (wait_done) state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_next = S_RTEXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_ADDI:       state_next = S_ADDIEX;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    OP_HALT:       state_next = S_HALT;
                    default: begin
                        state_next  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (wait_done) state_next = S_MEMWB;
            S_RTEXEC: begin
                if (funct_illegal) begin
                    state_next  = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_next = S_RTWB;
                end
            end
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP:
                state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // The wait counter reloads whenever FETCH or MEMRD is freshly entered.
    assign enter_wait = ((state_next == S_FETCH) && (state != S_FETCH)) ||
                        ((state_next == S_MEMRD) && (state != S_MEMRD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            illegal  <= 1'b0;
        end else begin
            state <= state_next;
            if (enter_wait) begin
                wait_cnt <= WAIT_LOAD;
            end else if (((state == S_FETCH) || (state == S_MEMRD)) && !wait_done) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (clear_illegal) begin
                illegal <= 1'b0;
            end else if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        PCen     = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        DRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALU_en   = 1'b0;
        PCSrc    = PCSRC_ALU;
        alu_use  = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB = SRCB_ONE;
                alu_use = 1'b1;
                IRWrite = wait_done;
                PCen    = wait_done;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;
                alu_use = 1'b1;
                ALU_en  = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_use = 1'b1;
                ALU_en  = 1'b1;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                DRWrite = wait_done;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_RTEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = is_shift(Funct) ? SRCB_SHAMT : SRCB_B;
                alu_use = 1'b1;
                ALU_en  = 1'b1;
            end
            S_RTWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                // Only Mealy output: the branch condition comes straight from Zero.
                ALUSrcA = 1'b1;
                alu_use = 1'b1;
                PCSrc   = PCSRC_ALUOUT;
                PCen    = (Opcode == OP_BNE) ? !Zero : Zero;
            end
            S_JUMP: begin
                PCSrc = PCSRC_JUMP;
                PCen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALUControl = alu_use ? dec_alu_control : '0;
    assign busy       = (state != S_IDLE) && (state != S_HALT);
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control: a per-instruction cycle schedule
// model predicts every output each cycle; directed runs pin cycle positions.
module tb_mips_multicycle_control;

    localparam int MW = 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       drwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] aluctl;
        logic       alu_en;
        logic [1:0] pcsrc;
        logic       busy;
        logic       halted;
        logic       illegal;
    } outv_t;

    typedef struct {
        outv_t v;
        logic  br;
        logic  br_ne;
        logic  skip_alu;
        logic  memrd;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       Zero = 1'b0;
    logic       PCen, IorD, MemWrite, IRWrite, DRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, ALU_en, busy, halted, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl;

    mips_multicycle_control #(
        .WORD_LENGTH (32),
        .MEM_WAIT    (MW),
        .ALU_CTRL_W  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .Zero       (Zero),
        .PCen       (PCen),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .DRWrite    (DRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ALU_en     (ALU_en),
        .PCSrc      (PCSrc),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state
    int          mode = M_IDLE;
    logic        ill = 1'b0;
    cyc_t        q[$];
    logic        end_halt, end_ill;
    logic [11:0] force_q[$];
    logic [5:0]  pend_op, pend_fn;
    logic        pend_valid = 1'b0;
    logic [5:0]  cur_op = 6'h00;
    int          cur_idx = 0;
    int          start_sel = 0;
    int          zero_sel = 0;

    // Observations of the most recent non-0x3F instruction
    int   seen_ir, seen_dr, seen_rw, n_rw, n_mw, n_mw_iord, last_len;
    logic seen_m2r, seen_br_pcen;

    logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic outv_t dut_out();
        outv_t a;
        a = '{pcen: PCen, iord: IorD, memwrite: MemWrite, irwrite: IRWrite, drwrite: DRWrite,
              regdst: RegDst, memtoreg: MemtoReg, regwrite: RegWrite, srca: ALUSrcA,
              srcb: ALUSrcB, aluctl: ALUControl, alu_en: ALU_en, pcsrc: PCSrc,
              busy: busy, halted: halted, illegal: illegal};
        return a;
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c.v        = '0;
        c.v.busy   = 1'b1;
        c.br       = 1'b0;
        c.br_ne    = 1'b0;
        c.skip_alu = 1'b0;
        c.memrd    = 1'b0;
        return c;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'h20: return 4'd2;
            6'h22: return 4'd6;
            6'h24: return 4'd0;
            6'h25: return 4'd1;
            6'h2A: return 4'd7;
            6'h00: return 4'd8;
            6'h02: return 4'd9;
            default: begin ok = 1'b0; return 4'd0; end
        endcase
    endfunction

    // Full cycle-by-cycle schedule of one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        logic ok;
        q.delete();
        end_halt = 1'b0;
        end_ill  = 1'b0;
        for (int i = 0; i <= MW; i++) begin
            c = blank(); c.v.srcb = 2'd1; c.v.aluctl = 4'd2;
            if (i == MW) begin c.v.irwrite = 1'b1; c.v.pcen = 1'b1; end
            q.push_back(c);
        end
        c = blank(); c.v.srcb = 2'd2; c.v.aluctl = 4'd2; c.v.alu_en = 1'b1;
        q.push_back(c);
        case (op)
            6'h00: begin
                c = blank(); c.v.srca = 1'b1; c.v.alu_en = 1'b1;
                c.v.srcb = (fn == 6'h00 || fn == 6'h02) ? 2'd3 : 2'd0;
                c.v.aluctl = alu_of(fn, ok);
                c.skip_alu = !ok;
                q.push_back(c);
                if (!ok) begin
                    end_halt = 1'b1; end_ill = 1'b1;
                end else begin
                    c = blank(); c.v.regdst = 1'b1; c.v.regwrite = 1'b1;
                    q.push_back(c);
                end
            end
            6'h23, 6'h2B: begin
                c = blank(); c.v.srca = 1'b1; c.v.srcb = 2'd2; c.v.aluctl = 4'd2; c.v.alu_en = 1'b1;
                q.push_back(c);
                if (op == 6'h23) begin
                    for (int i = 0; i <= MW; i++) begin
                        c = blank(); c.v.iord = 1'b1; c.memrd = 1'b1;
                        c.v.drwrite = (i == MW);
                        q.push_back(c);
                    end
                    c = blank(); c.v.memtoreg = 1'b1; c.v.regwrite = 1'b1;
                    q.push_back(c);
                end else begin
                    c = blank(); c.v.iord = 1'b1; c.v.memwrite = 1'b1;
                    q.push_back(c);
                end
            end
            6'h08: begin
                c = blank(); c.v.srca = 1'b1; c.v.srcb = 2'd2; c.v.aluctl = 4'd2; c.v.alu_en = 1'b1;
                q.push_back(c);
                c = blank(); c.v.regwrite = 1'b1;
                q.push_back(c);
            end
            6'h04, 6'h05: begin
                c = blank(); c.v.srca = 1'b1; c.v.aluctl = 4'd6; c.v.pcsrc = 2'd1;
                c.br = 1'b1; c.br_ne = (op == 6'h05);
                q.push_back(c);
            end
            6'h02: begin
                c = blank(); c.v.pcsrc = 2'd2; c.v.pcen = 1'b1;
                q.push_back(c);
            end
            6'h3F:   end_halt = 1'b1;
            default: begin end_halt = 1'b1; end_ill = 1'b1; end
        endcase
    endtask

    task automatic pick_random(output logic [5:0] op, output logic [5:0] fn);
        int r;
        r  = $urandom_range(0, 15);
        fn = fn_tab[$urandom_range(0, 6)];
        if (r <= 4)       op = 6'h00;
        else if (r <= 6)  op = 6'h23;
        else if (r <= 8)  op = 6'h2B;
        else if (r == 9)  op = 6'h08;
        else if (r <= 11) op = 6'h04;
        else if (r == 12) op = 6'h05;
        else if (r == 13) op = 6'h02;
        else if (r == 14) op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 63));
        else begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
    endtask

    task automatic new_instr();
        logic [5:0] op, fn;
        if (force_q.size() > 0) begin
            {op, fn} = force_q.pop_front();
        end else begin
            pick_random(op, fn);
        end
        build(op, fn);
        pend_op = op; pend_fn = fn; pend_valid = 1'b1;
        mode = M_RUN; cur_idx = 1; cur_op = op;
        if (op != 6'h3F) begin
            seen_ir = 0; seen_dr = 0; seen_rw = 0; n_rw = 0; n_mw = 0; n_mw_iord = 0;
            last_len = 0; seen_m2r = 1'b0; seen_br_pcen = 1'b0;
        end
    endtask

    // One clock cycle: drive, compare mid-cycle, advance the model.
    task automatic step();
        outv_t e, m, a;
        if (pend_valid) begin Opcode = pend_op; Funct = pend_fn; pend_valid = 1'b0; end
        case (zero_sel)
            1:       Zero = 1'b1;
            2:       Zero = 1'b0;
            default: Zero = 1'($urandom_range(0, 1));
        endcase
        case (start_sel)
            0:       start = 1'b0;
            1:       start = 1'b1;
            default: start = ($urandom_range(0, 2) == 0);
        endcase
        #1;
        e = '0;
        m = '1;
        if (mode == M_RUN) begin
            e = q[0].v;
            if (q[0].br) e.pcen = q[0].br_ne ? !Zero : Zero;
            if (q[0].skip_alu) m.aluctl = '0;
        end else if (mode == M_HALT) begin
            e.halted  = 1'b1;
            e.illegal = ill;
        end
        a = dut_out();
        check("outputs", 32'(a & m), 32'(e & m));
        if (mode == M_RUN && cur_op != 6'h3F) begin
            if (IRWrite) seen_ir = cur_idx;
            if (DRWrite) seen_dr = cur_idx;
            if (RegWrite) begin seen_rw = cur_idx; seen_m2r = MemtoReg; n_rw++; end
            if (MemWrite) begin n_mw++; if (IorD) n_mw_iord++; end
            if (q[0].br) seen_br_pcen = PCen;
        end
        if (mode == M_RUN) begin
            void'(q.pop_front());
            cur_idx++;
            if (q.size() == 0) begin
                if (cur_op != 6'h3F) last_len = cur_idx - 1;
                if (end_halt) begin mode = M_HALT; ill = end_ill; end
                else new_instr();
            end
        end else if (start) begin
            ill = 1'b0;
            new_instr();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_stop(input int bound);
        int n = 0;
        while (mode == M_RUN && n < bound) begin step(); n++; end
        check("run_bound", 32'(mode == M_RUN), 32'd0);
    endtask

    // Launch one instruction from IDLE/HALT, optionally followed by a 0x3F halt.
    task automatic directed(input logic [5:0] op, input logic [5:0] fn, input logic chain);
        force_q.push_back({op, fn});
        if (chain) force_q.push_back({6'h3F, 6'h00});
        start_sel = 1;
        step();
        start_sel = 0;
        run_until_stop(60);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #1;
        check("reset_outputs", 32'(dut_out()), 32'd0);
        @(negedge clk);
        check("reset_outputs_hold", 32'(dut_out()), 32'd0);
        reset = 1'b1;
        start_sel = 0;
        step();
        step();

        // R-type add
        directed(6'h00, 6'h20, 1'b1);
        check("rtype_irwrite_cycle", 32'(seen_ir), 32'(MW + 1));
        check("rtype_regwrite_cycle", 32'(seen_rw), 32'(MW + 4));
        check("rtype_len", 32'(last_len), 32'(MW + 4));

        // lw
        directed(6'h23, 6'h00, 1'b1);
        check("lw_irwrite_cycle", 32'(seen_ir), 32'(MW + 1));
        check("lw_drwrite_cycle", 32'(seen_dr), 32'(2 * MW + 4));
        check("lw_regwrite_cycle", 32'(seen_rw), 32'(2 * MW + 5));
        check("lw_memtoreg", 32'(seen_m2r), 32'd1);
        check("lw_len", 32'(last_len), 32'(2 * MW + 5));

        // Branches under forced Zero
        zero_sel = 1; directed(6'h04, 6'h00, 1'b1);
        check("beq_taken_pcen", 32'(seen_br_pcen), 32'd1);
        check("beq_len", 32'(last_len), 32'(MW + 3));
        zero_sel = 2; directed(6'h04, 6'h00, 1'b1);
        check("beq_not_taken_pcen", 32'(seen_br_pcen), 32'd0);
        zero_sel = 1; directed(6'h05, 6'h00, 1'b1);
        check("bne_zero_pcen", 32'(seen_br_pcen), 32'd0);
        zero_sel = 2; directed(6'h05, 6'h00, 1'b1);
        check("bne_nonzero_pcen", 32'(seen_br_pcen), 32'd1);
        zero_sel = 0;

        // sw
        directed(6'h2B, 6'h00, 1'b1);
        check("sw_memwrite_count", 32'(n_mw), 32'd1);
        check("sw_memwrite_iord", 32'(n_mw_iord), 32'd1);
        check("sw_regwrite_count", 32'(n_rw), 32'd0);
        check("sw_len", 32'(last_len), 32'(MW + 4));

        // Halt, illegal opcode, illegal funct, restart
        directed(6'h3F, 6'h00, 1'b0);
        check("halt_flags", {29'd0, halted, busy, illegal}, 32'b100);
        directed(6'h11, 6'h00, 1'b0);
        check("illegal_op_flags", {29'd0, halted, busy, illegal}, 32'b101);
        start_sel = 1;
        step();
        start_sel = 0;
        check("restart_flags", {29'd0, halted, busy, illegal}, 32'b010);
        run_until_stop(60);
        directed(6'h00, 6'h3B, 1'b0);
        check("illegal_funct_flags", {29'd0, halted, busy, illegal}, 32'b101);

        // Random traffic
        start_sel = 2;
        repeat (2500) step();

        // Reset in the middle of a load's memory wait
        force_q.push_back({6'h23, 6'h00});
        n = 0;
        while (!(mode == M_RUN && q.size() > 0 && q[0].memrd) && n < 300) begin
            step();
            n++;
        end
        check("memrd_reached", 32'(mode == M_RUN && q.size() > 0 && q[0].memrd), 32'd1);
        #2 reset = 1'b0;
        #1 check("reset_async_outputs", 32'(dut_out()), 32'd0);
        mode = M_IDLE; q.delete(); ill = 1'b0; pend_valid = 1'b0; force_q.delete();
        @(negedge clk);
        check("reset_async_hold", 32'(dut_out()), 32'd0);
        reset = 1'b1;
        start_sel = 0;
        repeat (6) step();
        check("idle_after_reset", {30'd0, busy, halted}, 32'd0);
        start_sel = 1;
        step();
        start_sel = 2;
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
